// File: rtl/ram_seq_ctrl_pkg.sv
// Shared types and default widths for the RAM request sequencer.
// The RAM_OUTREG_EN build adds the WAIT_A/WAIT_B states; the enum always declares them.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DFLT = 8;
  localparam int unsigned DATA_W_DFLT = 16;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ADD   = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_A = 3'd1,
    ST_WAIT_A  = 3'd2,
    ST_CAP_A   = 3'd3,
    ST_WAIT_B  = 3'd4,
    ST_CAP_B   = 3'd5,
    ST_WR      = 3'd6,
    ST_RESP    = 3'd7
  } state_t;

endpackage

// File: rtl/ram_seq_ctrl_if.sv
// Request/response bus between a processor (master) and the sequencer (slave).
interface ram_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) ();

  logic              ReqValid;
  logic              ReqReady;
  logic [1:0]        ReqOp;
  logic [ADDR_W-1:0] ReqAddrA;
  logic [ADDR_W-1:0] ReqAddrB;
  logic [ADDR_W-1:0] ReqAddrD;
  logic [DATA_W-1:0] ReqData;
  logic              RspValid;
  logic [DATA_W-1:0] RspData;
  logic              RspErr;
  logic              RspCarry;

  modport master (
    output ReqValid, ReqOp, ReqAddrA, ReqAddrB, ReqAddrD, ReqData,
    input  ReqReady, RspValid, RspData, RspErr, RspCarry
  );

  modport slave (
    input  ReqValid, ReqOp, ReqAddrA, ReqAddrB, ReqAddrD, ReqData,
    output ReqReady, RspValid, RspData, RspErr, RspCarry
  );

endinterface

// File: rtl/myRAM1.sv
// Single-port synchronous RAM: registered address, q follows the sampled address.
// With RAM_OUTREG_EN defined, q is registered once more (2-cycle read latency).
module myRAM1 #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_q;

  // Address register and write port
  always_ff @(posedge clock) begin
    addr_q <= address;
    if (wren) mem_q[address] <= data;
  end

`ifdef RAM_OUTREG_EN
  logic [DATA_W-1:0] q_q;

  // Optional output register
  always_ff @(posedge clock) begin
    q_q <= mem_q[addr_q];
  end

  assign q = q_q;
`else
  assign q = mem_q[addr_q];
`endif

endmodule

// File: rtl/ram_seq_ctrl.sv
// Sequencer turning READ/WRITE/ADD requests into timed RAM address/data/wren
// cycles with one response per request. Define RAM_OUTREG_EN for a RAM with
// registered q: adds a wait cycle after each address issue.
module ram_seq_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DFLT,
  parameter int unsigned DATA_W = DATA_W_DFLT
) (
  input  logic              Clk,
  input  logic              Reset,
  ram_seq_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [DATA_W-1:0] RamData,
  output logic              RamWren,
  input  logic [DATA_W-1:0] RamQ
);

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] b_q, b_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic [DATA_W:0]   sum_full_c;

  // Full-width sum of operand A (held in X) and operand B arriving on RamQ
  assign sum_full_c = {1'b0, x_q} + {1'b0, RamQ};

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    dst_d       = dst_q;
    wdata_d     = wdata_q;
    x_d         = x_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_wren_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_carry_d = rsp_carry_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.ReqValid && req_ready_q) begin
          op_d    = op_t'(bus.ReqOp);
          a_d     = bus.ReqAddrA;
          b_d     = bus.ReqAddrB;
          dst_d   = bus.ReqAddrD;
          wdata_d = bus.ReqData;
          case (op_t'(bus.ReqOp))
            OP_READ, OP_ADD: begin
              state_d    = ST_ISSUE_A;
              ram_addr_d = bus.ReqAddrA;
              ram_data_d = '0;
            end
            OP_WRITE: begin
              state_d    = ST_WR;
              ram_addr_d = bus.ReqAddrD;
              ram_data_d = bus.ReqData;
              ram_wren_d = 1'b1;
            end
            default: begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_err_d   = 1'b1;
              rsp_carry_d = 1'b0;
            end
          endcase
        end
      end

      ST_ISSUE_A: begin
`ifdef RAM_OUTREG_EN
        state_d = ST_WAIT_A;
`else
        state_d = ST_CAP_A;
        if (op_q == OP_ADD) ram_addr_d = b_q;
`endif
      end

      ST_WAIT_A: begin
        state_d = ST_CAP_A;
        if (op_q == OP_ADD) ram_addr_d = b_q;
      end

      ST_CAP_A: begin
        x_d = RamQ;
        if (op_q == OP_ADD) begin
`ifdef RAM_OUTREG_EN
          state_d = ST_WAIT_B;
`else
          state_d = ST_CAP_B;
`endif
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = RamQ;
          rsp_err_d   = 1'b0;
          rsp_carry_d = 1'b0;
          ram_addr_d  = '0;
          ram_data_d  = '0;
        end
      end

      ST_WAIT_B: begin
        state_d = ST_CAP_B;
      end

      ST_CAP_B: begin
        state_d    = ST_WR;
        sum_d      = sum_full_c[DATA_W-1:0];
        carry_d    = sum_full_c[DATA_W];
        ram_addr_d = dst_q;
        ram_data_d = sum_full_c[DATA_W-1:0];
        ram_wren_d = 1'b1;
      end

      ST_WR: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = (op_q == OP_WRITE) ? wdata_q : sum_q;
        rsp_err_d   = 1'b0;
        rsp_carry_d = (op_q == OP_ADD) ? carry_q : 1'b0;
        ram_addr_d  = '0;
        ram_data_d  = '0;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      a_q         <= '0;
      b_q         <= '0;
      dst_q       <= '0;
      wdata_q     <= '0;
      x_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_wren_q  <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dst_q       <= dst_d;
      wdata_q     <= wdata_d;
      x_q         <= x_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_wren_q  <= ram_wren_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  // Write enable is masked by Reset so an interrupted write never commits
  assign RamWren      = ram_wren_q & ~Reset;
  assign RamAddr      = ram_addr_q;
  assign RamData      = ram_data_q;
  assign bus.ReqReady = req_ready_q;
  assign bus.RspValid = rsp_valid_q;
  assign bus.RspData  = rsp_data_q;
  assign bus.RspErr   = rsp_err_q;
  assign bus.RspCarry = rsp_carry_q;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Bench for ram_seq_ctrl driving a myRAM1 instance; expected results come from
// a memory-array reference model. Honours RAM_OUTREG_EN for latency.
module tb_ram_seq_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
`ifdef RAM_OUTREG_EN
  localparam int READ_LAT = 4;
  localparam int ADD_LAT  = 7;
`else
  localparam int READ_LAT = 3;
  localparam int ADD_LAT  = 5;
`endif
  localparam int WRITE_LAT = 2;
  localparam int RSVD_LAT  = 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;
  logic          ram_wren;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_ref [256];

  always #5 Clk = ~Clk;

  ram_seq_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .bus     (bus),
    .RamAddr (ram_addr),
    .RamData (ram_data),
    .RamWren (ram_wren),
    .RamQ    (ram_q)
  );

  myRAM1 #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
    .clock   (Clk),
    .address (ram_addr),
    .data    (ram_data),
    .wren    (ram_wren),
    .q       (ram_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, follow it to its response and compare with the model.
  task automatic run_req(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d, input logic [DW-1:0] data, input string tag);
    int            exp_lat;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    logic          exp_carry;
    logic [DW:0]   full;
    int            lat;
    int            wren_cnt;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] got_data;
    logic          got_err;
    logic          got_carry;

    exp_err   = 1'b0;
    exp_carry = 1'b0;
    full      = '0;
    case (op)
      2'b00: begin exp_lat = READ_LAT;  exp_data = mem_ref[a]; end
      2'b01: begin exp_lat = WRITE_LAT; exp_data = data; end
      2'b10: begin
        exp_lat   = ADD_LAT;
        full      = {1'b0, mem_ref[a]} + {1'b0, mem_ref[b]};
        exp_data  = full[DW-1:0];
        exp_carry = full[DW];
      end
      default: begin exp_lat = RSVD_LAT; exp_data = '0; exp_err = 1'b1; end
    endcase

    @(negedge Clk);
    check({tag, " ready"}, 32'(bus.ReqReady), 32'd1);
    bus.ReqValid = 1'b1;
    bus.ReqOp    = op;
    bus.ReqAddrA = a;
    bus.ReqAddrB = b;
    bus.ReqAddrD = d;
    bus.ReqData  = data;
    @(posedge Clk);
    #1;
    bus.ReqValid = 1'b0;
    bus.ReqOp    = 2'($urandom);
    bus.ReqAddrA = AW'($urandom);
    bus.ReqAddrB = AW'($urandom);
    bus.ReqAddrD = AW'($urandom);
    bus.ReqData  = DW'($urandom);

    lat       = 0;
    wren_cnt  = 0;
    waddr     = '0;
    wdata     = '0;
    got_data  = '0;
    got_err   = 1'b0;
    got_carry = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) begin
        @(posedge Clk);
        #1;
      end
      if (ram_wren) begin
        wren_cnt++;
        waddr = ram_addr;
        wdata = ram_data;
      end
      if (bus.RspValid) begin
        lat       = c;
        got_data  = bus.RspData;
        got_err   = bus.RspErr;
        got_carry = bus.RspCarry;
        break;
      end
    end

    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rsp_data"}, 32'(got_data), 32'(exp_data));
    check({tag, " rsp_err"}, 32'(got_err), 32'(exp_err));
    if (op == 2'b10) check({tag, " rsp_carry"}, 32'(got_carry), 32'(exp_carry));
    if (op == 2'b01 || op == 2'b10) begin
      check({tag, " wren_cycles"}, 32'(wren_cnt), 32'd1);
      check({tag, " wren_addr"}, 32'(waddr), 32'(d));
      check({tag, " wren_data"}, 32'(wdata), 32'(exp_data));
      mem_ref[d] = exp_data;
    end else begin
      check({tag, " wren_cycles"}, 32'(wren_cnt), 32'd0);
    end

    @(posedge Clk);
    #1;
    check({tag, " pulse_end"}, 32'(bus.RspValid), 32'd0);
    check({tag, " ready_after"}, 32'(bus.ReqReady), 32'd1);
    check({tag, " idle_addr"}, 32'(ram_addr), 32'd0);
    check({tag, " idle_data"}, 32'(ram_data), 32'd0);
    check({tag, " idle_wren"}, 32'(ram_wren), 32'd0);
    check({tag, " held_data"}, 32'(bus.RspData), 32'(exp_data));
  endtask

  initial begin
    Reset        = 1'b1;
    bus.ReqValid = 1'b0;
    bus.ReqOp    = 2'b00;
    bus.ReqAddrA = '0;
    bus.ReqAddrB = '0;
    bus.ReqAddrD = '0;
    bus.ReqData  = '0;
    for (int i = 0; i < 256; i++) mem_ref[i] = '0;

    repeat (2) @(posedge Clk);
    #1;
    check("rst ready", 32'(bus.ReqReady), 32'd1);
    check("rst rsp_valid", 32'(bus.RspValid), 32'd0);
    check("rst rsp_data", 32'(bus.RspData), 32'd0);
    check("rst rsp_err", 32'(bus.RspErr), 32'd0);
    check("rst rsp_carry", 32'(bus.RspCarry), 32'd0);
    check("rst ram_addr", 32'(ram_addr), 32'd0);
    check("rst ram_data", 32'(ram_data), 32'd0);
    check("rst ram_wren", 32'(ram_wren), 32'd0);
    Reset = 1'b0;

    // Directed plan
    run_req(2'b01, 8'd99, 8'd77, 8'd5, 16'd10, "wr5");
    run_req(2'b01, 8'd3, 8'd4, 8'd41, 16'd20, "wr41");
    run_req(2'b00, 8'd5, 8'd41, 8'd9, 16'hBEEF, "rd5");
    run_req(2'b10, 8'd5, 8'd41, 8'd7, 16'h1234, "add7");
    run_req(2'b00, 8'd7, 8'd0, 8'd0, 16'd0, "rd7");
    run_req(2'b01, 8'd0, 8'd0, 8'd5, 16'hFFFF, "wr5_ffff");
    run_req(2'b01, 8'd0, 8'd0, 8'd41, 16'h0002, "wr41_2");
    run_req(2'b10, 8'd5, 8'd41, 8'd5, 16'd0, "add_alias");
    run_req(2'b00, 8'd5, 8'd0, 8'd0, 16'd0, "rd5_alias");
    run_req(2'b10, 8'd7, 8'd7, 8'd7, 16'd0, "add_self");
    run_req(2'b11, 8'd5, 8'd41, 8'd5, 16'h5555, "rsvd");
    run_req(2'b11, 8'd1, 8'd2, 8'd3, 16'h0, "rsvd2");

    // Reset while the ADD sits in its write cycle
    @(negedge Clk);
    bus.ReqValid = 1'b1;
    bus.ReqOp    = 2'b10;
    bus.ReqAddrA = 8'd5;
    bus.ReqAddrB = 8'd41;
    bus.ReqAddrD = 8'd41;
    bus.ReqData  = '0;
    @(posedge Clk);
    #1;
    bus.ReqValid = 1'b0;
    repeat (ADD_LAT - 2) begin
      @(posedge Clk);
      #1;
    end
    check("rstmid in_wr", 32'(ram_wren), 32'd1);
    Reset = 1'b1;
    #1;
    check("rstmid wren_gated", 32'(ram_wren), 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("rstmid ready", 32'(bus.ReqReady), 32'd1);
    check("rstmid rsp_valid", 32'(bus.RspValid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      check("rstmid no_rsp", 32'(bus.RspValid), 32'd0);
      check("rstmid no_wren", 32'(ram_wren), 32'd0);
    end
    run_req(2'b00, 8'd41, 8'd0, 8'd0, 16'd0, "rstmid rd41");

    // Randomized traffic over a small, fully initialised address window
    for (int i = 0; i < 16; i++)
      run_req(2'b01, AW'($urandom), AW'($urandom), AW'(i), DW'($urandom), "rnd_init");
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      run_req(op, AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
              AW'($urandom_range(0, 15)), DW'($urandom), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
